// File: rtl/rgmii_rx.sv
// RGMII receiver: DDR capture, preamble/SFD strip, header and FCS check, payload into a double-banked RAM.
// Payload write appears 1 cycle after each byte strobe; frm_ok comes at most 2 cycles after DV falls.
module rgmii_rx #(
    parameter logic [47:0] MAC     = 48'h5965239093d4,
    parameter logic [15:0] ETYPE   = 16'h1919,
    parameter int          PAYLOAD = 1024,
    parameter int          CNTW    = 16,
    localparam int         AW      = $clog2(PAYLOAD)
) (
    input  logic            clk125,
    input  logic            rst_n,
    input  logic            rxctl,
    input  logic [3:0]      rxd,
    output logic            wr_en,
    output logic [AW:0]     wr_ad,
    output logic [7:0]      wr_data,
    output logic            rdy_idx,
    output logic [15:0]     seq,
    output logic            frm_ok,
    output logic [CNTW-1:0] crc_err_cnt,
    output logic [CNTW-1:0] drop_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_FCS, S_CHK, S_DROP} state_t;

    state_t          r_state;
    logic [3:0]      r_lo, r_hi;
    logic            r_dv, r_fctl;
    logic [3:0]      r_n;
    logic [AW-1:0]   r_k;
    logic [31:0]     r_crc;
    logic [15:0]     r_seq_tmp, r_seq;
    logic            r_bank, r_rdy, r_ok, r_wr_en;
    logic [AW:0]     r_wr_ad;
    logic [7:0]      r_wr_data;
    logic [CNTW-1:0] r_crc_err, r_drop;

    logic [7:0]      w_byte;
    logic            w_er, w_hdr_bad;
    logic [31:0]     w_crc_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Rising edge carries the low nibble and DV, falling edge the high nibble and DV^ER.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_lo <= 4'h0;
            r_dv <= 1'b0;
        end else begin
            r_lo <= rxd;
            r_dv <= rxctl;
        end
    end

    always_ff @(negedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= 4'h0;
            r_fctl <= 1'b0;
        end else begin
            r_hi   <= rxd;
            r_fctl <= rxctl;
        end
    end

    assign w_byte     = {r_hi, r_lo};
    assign w_er       = r_dv & (r_dv ^ r_fctl);
    assign w_crc_next = crc_byte(r_crc, w_byte);

    always_comb begin
        w_hdr_bad = 1'b0;
        case (r_n)
            4'd0:  w_hdr_bad = (w_byte != MAC[7:0]);
            4'd1:  w_hdr_bad = (w_byte != MAC[15:8]);
            4'd2:  w_hdr_bad = (w_byte != MAC[23:16]);
            4'd3:  w_hdr_bad = (w_byte != MAC[31:24]);
            4'd4:  w_hdr_bad = (w_byte != MAC[39:32]);
            4'd5:  w_hdr_bad = (w_byte != MAC[47:40]);
            4'd12: w_hdr_bad = (w_byte != ETYPE[15:8]);
            4'd13: w_hdr_bad = (w_byte != ETYPE[7:0]);
            default: w_hdr_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_n       <= 4'd0;
            r_k       <= '0;
            r_crc     <= 32'hFFFFFFFF;
            r_seq_tmp <= 16'h0;
            r_seq     <= 16'h0;
            r_bank    <= 1'b0;
            r_rdy     <= 1'b0;
            r_ok      <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_ad   <= '0;
            r_wr_data <= 8'h0;
            r_crc_err <= '0;
            r_drop    <= '0;
        end else begin
            r_ok    <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: if (r_dv) r_state <= (!w_er && w_byte == 8'h55) ? S_PRE : S_DROP;
                S_PRE: begin
                    if (!r_dv)                 r_state <= S_IDLE;
                    else if (w_er)             r_state <= S_DROP;
                    else if (w_byte == 8'hD5) begin
                        r_state <= S_HDR;
                        r_n     <= 4'd0;
                        r_crc   <= 32'hFFFFFFFF;
                    end else if (w_byte != 8'h55) r_state <= S_DROP;
                end
                S_HDR: begin
                    if (!r_dv) begin
                        r_drop  <= sat_inc(r_drop);
                        r_state <= S_IDLE;
                    end else if (w_er || w_hdr_bad) begin
                        r_state <= S_DROP;
                    end else begin
                        r_crc <= w_crc_next;
                        r_n   <= r_n + 4'd1;
                        if (r_n == 4'd14) r_seq_tmp[7:0] <= w_byte;
                        if (r_n == 4'd15) begin
                            r_seq_tmp[15:8] <= w_byte;
                            r_k             <= '0;
                            r_state         <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (!r_dv) begin
                        r_drop  <= sat_inc(r_drop);
                        r_state <= S_IDLE;
                    end else if (w_er) begin
                        r_state <= S_DROP;
                    end else begin
                        r_crc     <= w_crc_next;
                        r_wr_en   <= 1'b1;
                        r_wr_ad   <= {r_bank, r_k};
                        r_wr_data <= w_byte;
                        r_k       <= r_k + 1'b1;
                        if (r_k == AW'(PAYLOAD - 1)) begin
                            r_n     <= 4'd0;
                            r_state <= S_FCS;
                        end
                    end
                end
                S_FCS: begin
                    if (!r_dv) begin
                        r_drop  <= sat_inc(r_drop);
                        r_state <= S_IDLE;
                    end else if (w_er) begin
                        r_state <= S_DROP;
                    end else begin
                        r_crc <= w_crc_next;
                        r_n   <= r_n + 4'd1;
                        if (r_n == 4'd3) r_state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (!r_dv) begin
                        // Residue of a correct frame with the FCS folded in.
                        if (r_crc == 32'hDEBB20E3) begin
                            r_ok   <= 1'b1;
                            r_seq  <= r_seq_tmp;
                            r_rdy  <= r_bank;
                            r_bank <= ~r_bank;
                        end else begin
                            r_crc_err <= sat_inc(r_crc_err);
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: if (!r_dv) begin
                    r_drop  <= sat_inc(r_drop);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_ad       = r_wr_ad;
    assign wr_data     = r_wr_data;
    assign rdy_idx     = r_rdy;
    assign seq         = r_seq;
    assign frm_ok      = r_ok;
    assign crc_err_cnt = r_crc_err;
    assign drop_cnt    = r_drop;
endmodule

// File: tb/tb_rgmii_rx.sv
// Bench for rgmii_rx: builds whole frames (preamble, header, payload, FCS) and checks outputs against a frame-level model.
module tb_rgmii_rx;
    localparam int PAYLOAD = 1024;
    localparam logic [47:0] MAC = 48'h5965239093d4;
    localparam int K_GOOD = 0, K_FLIP = 1, K_MAC = 2, K_ETYPE = 3, K_SHORT = 4, K_EXTRA = 5, K_ER = 6;

    logic        clk125 = 1'b0;
    logic        rst_n, rxctl;
    logic [3:0]  rxd;
    logic        wr_en, rdy_idx, frm_ok;
    logic [10:0] wr_ad;
    logic [7:0]  wr_data;
    logic [15:0] seq, crc_err_cnt, drop_cnt;

    rgmii_rx dut (
        .clk125(clk125), .rst_n(rst_n), .rxctl(rxctl), .rxd(rxd),
        .wr_en(wr_en), .wr_ad(wr_ad), .wr_data(wr_data), .rdy_idx(rdy_idx),
        .seq(seq), .frm_ok(frm_ok), .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt)
    );

    always #4 clk125 = ~clk125;

    typedef struct {
        int          kind;
        int          mod_at;
        int          pat;
        logic [15:0] sq;
        int          e_ok;
        int          e_crc;
        int          e_drop;
        bit          chk_wr;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    logic [10:0] got_ad[$];
    logic [7:0]  got_dat[$];
    int          ok_pulses = 0;

    logic [7:0] fr[$];
    logic [7:0] pay[PAYLOAD];
    int         er_idx, nwr;

    bit          m_bank = 1'b0, m_rdy = 1'b0;
    logic [15:0] m_seq = 16'h0;
    int          m_crc = 0, m_drop = 0;

    always @(negedge clk125) begin
        if (rst_n === 1'b1) begin
            if (wr_en) begin
                got_ad.push_back(wr_ad);
                got_dat.push_back(wr_data);
            end
            if (frm_ok) ok_pulses++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dv, input logic er);
        @(negedge clk125); #2;
        rxd = b[3:0]; rxctl = dv;
        @(posedge clk125); #2;
        rxd = b[7:4]; rxctl = dv ^ er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h00, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] crc32(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    task automatic build_frame(input int kind, input int mod_at, input int pat, input logic [15:0] sq);
        logic [31:0] c;
        logic [7:0]  b;
        fr.delete();
        for (int i = 0; i < 7; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        for (int k = 0; k < 6; k++) fr.push_back(MAC[8*k +: 8]);
        for (int k = 0; k < 6; k++) fr.push_back(8'($urandom));
        fr.push_back(8'h19); fr.push_back(8'h19);
        fr.push_back(sq[7:0]); fr.push_back(sq[15:8]);
        for (int i = 0; i < PAYLOAD; i++) begin
            pay[i] = (pat == 0) ? 8'(i) : 8'($urandom);
            fr.push_back(pay[i]);
        end
        c = 32'hFFFFFFFF;
        for (int i = 8; i < fr.size(); i++) c = crc32(c, fr[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            b = c[8*k +: 8];
            fr.push_back(b);
        end
        er_idx = -1;
        nwr = PAYLOAD;
        case (kind)
            K_FLIP:  begin fr[24 + mod_at] ^= 8'h10; pay[mod_at] ^= 8'h10; end
            K_MAC:   begin fr[8] = 8'hD5; nwr = 0; end
            K_ETYPE: begin fr[20] = 8'h08; fr[21] = 8'h00; nwr = 0; end
            K_SHORT: begin
                while (fr.size() > 24 + mod_at) void'(fr.pop_back());
                nwr = mod_at;
            end
            K_EXTRA: fr.push_back(8'hA5);
            K_ER:    er_idx = 24 + mod_at;
            default: ;
        endcase
    endtask

    task automatic run_frame(input vec_t v);
        int  base, ok0, mism;
        bit  bank_used;
        build_frame(v.kind, v.mod_at, v.pat, v.sq);
        base = got_ad.size();
        ok0  = ok_pulses;
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 1'b1, i == er_idx);
        idle(12);
        bank_used = m_bank;
        if (v.e_ok != 0) begin
            m_rdy  = m_bank;
            m_bank = ~m_bank;
            m_seq  = v.sq;
        end
        m_crc  += v.e_crc;
        m_drop += v.e_drop;
        chk("frm_ok_pulses", 32'(ok_pulses - ok0), 32'(v.e_ok));
        chk("crc_err_cnt", 32'(crc_err_cnt), 32'(m_crc));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("rdy_idx", 32'(rdy_idx), 32'(m_rdy));
        chk("seq", 32'(seq), 32'(m_seq));
        if (v.chk_wr) begin
            chk("wr_count", 32'(got_ad.size() - base), 32'(nwr));
            mism = 0;
            for (int k = 0; k < nwr && base + k < got_ad.size(); k++)
                if (got_ad[base + k] !== {bank_used, 10'(k)} || got_dat[base + k] !== pay[k]) mism++;
            chk("wr_ad_data_mismatches", 32'(mism), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_ad"}, 32'(wr_ad), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_rdy_idx"}, 32'(rdy_idx), 32'd0);
        chk({tag, "_seq"}, 32'(seq), 32'd0);
        chk({tag, "_frm_ok"}, 32'(frm_ok), 32'd0);
        chk({tag, "_crc_err_cnt"}, 32'(crc_err_cnt), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        vecs[0] = '{K_GOOD,  0,   0, 16'h0001, 1, 0, 0, 1'b1};
        vecs[1] = '{K_GOOD,  0,   1, 16'h0002, 1, 0, 0, 1'b1};
        vecs[2] = '{K_FLIP,  77,  1, 16'h0003, 0, 1, 0, 1'b1};
        vecs[3] = '{K_GOOD,  0,   1, 16'h0004, 1, 0, 0, 1'b1};
        vecs[4] = '{K_MAC,   0,   1, 16'h0005, 0, 0, 1, 1'b1};
        vecs[5] = '{K_ETYPE, 0,   1, 16'h0006, 0, 0, 1, 1'b1};
        vecs[6] = '{K_SHORT, 500, 1, 16'h0007, 0, 0, 1, 1'b1};
        vecs[7] = '{K_EXTRA, 0,   1, 16'h0008, 0, 0, 1, 1'b1};
        vecs[8] = '{K_ER,    300, 1, 16'h0009, 0, 0, 1, 1'b0};

        rst_n = 1'b0; rxctl = 1'b0; rxd = 4'h0;
        repeat (3) @(negedge clk125);
        chk_all_zero("reset");
        @(posedge clk125); #2;
        rst_n = 1'b1;
        idle(3);

        for (int i = 0; i < 9; i++) run_frame(vecs[i]);

        // Abort a frame part-way through the payload with reset.
        build_frame(K_GOOD, 0, 1, 16'h00AA);
        for (int i = 0; i < 24 + 300; i++) send_byte(fr[i], 1'b1, 1'b0);
        rst_n = 1'b0; rxctl = 1'b0;
        repeat (3) @(negedge clk125);
        chk_all_zero("midframe_reset");
        @(posedge clk125); #2;
        rst_n = 1'b1;
        idle(5);
        m_bank = 1'b0; m_rdy = 1'b0; m_seq = 16'h0; m_crc = 0; m_drop = 0;
        chk("post_reset_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("post_reset_crc_err_cnt", 32'(crc_err_cnt), 32'd0);
        run_frame('{K_GOOD, 0, 1, 16'hFFFF, 1, 0, 0, 1'b1});

        for (int r = 0; r < 4; r++) begin
            rv.pat = 1;
            rv.sq = 16'($urandom);
            rv.mod_at = $urandom_range(1, PAYLOAD - 1);
            rv.chk_wr = 1'b1;
            case ($urandom_range(0, 2))
                0:       begin rv.kind = K_GOOD;  rv.e_ok = 1; rv.e_crc = 0; rv.e_drop = 0; end
                1:       begin rv.kind = K_FLIP;  rv.e_ok = 0; rv.e_crc = 1; rv.e_drop = 0; end
                default: begin rv.kind = K_SHORT; rv.e_ok = 0; rv.e_crc = 0; rv.e_drop = 1; end
            endcase
            run_frame(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
